peak_detector: RTL
==================

# peak_detector

Pulse-height analyser directly downstream of the trapezoidal shaping filter. Consumes the filter's signed sample stream (one sample per `clk`), finds each pulse that crosses a programmable threshold, and reports its maximum amplitude and the timestamp of that maximum through a valid/ready output register. Lost events and rejected pile-up are tallied in saturating counters.

## Interface
- `SIZE_FILTER_DATA`, 16: input sample and `peak_amp` width, signed two's complement.
- `TS_W`, 32: timestamp counter width.
- `HYST`, 20: fall/rebound hysteresis, in LSBs, unsigned.
- `HOLDOFF_CYCLES`, 4: dead time after each emission, ≥1.
- `CNT_W`, 16: width of the `lost_count` and `pileup_count` counters.
- `clk`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high.
- `input_data`  in  SIZE_FILTER_DATA: filter output, new sample every cycle.
- `threshold`  in  SIZE_FILTER_DATA: signed arming level, quasi-static.
- `peak_amp`  out  SIZE_FILTER_DATA: maximum sample of the reported pulse.
- `peak_time`  out  TS_W: timestamp of that maximum.
- `peak_valid`  out  1: event present.
- `peak_ready`  in  1: consumer accepts the event.
- `lost_count`  out  CNT_W: events dropped because the output register was full.
- `pileup_count`  out  CNT_W: events rejected as pile-up. Tied to 0 when the feature is compiled out.

## Operation
- Free-running `ts` counter: increments every cycle and wraps modulo 2^TS_W.
- FSM states: IDLE, RISE, FALL, HOLDOFF.
- IDLE:
  - if `input_data > threshold` (strict, signed): go to RISE, `max ← x`, `tmax ← ts`, latch `threshold` into `thr_l`.
  - A sample equal to the threshold never arms.
- RISE:
  - `x > max`: update `max` and `tmax`.
  - `x ≤ thr_l`: emit, go to HOLDOFF.
  - else if `x < max − HYST`: go to FALL, `valley ← x`.
- FALL:
  - `x ≤ thr_l`: emit, go to HOLDOFF.
  - else `x < valley`: `valley ← x`.
  - else `x > valley + HYST`: rebound. Go to RISE, and `x > max` updates `max` and `tmax`.
- HOLDOFF: count `HOLDOFF_CYCLES` samples. Afterwards go to IDLE only once `x ≤ thr_l`; stay in HOLDOFF while above.
- Arithmetic: all hysteresis comparisons are done in SIZE_FILTER_DATA+1 signed bits, so `max − HYST` and `valley + HYST` never wrap.
- Emit:
  - if `peak_valid` is low, or `peak_ready` is high in the same cycle: load `peak_amp ← max`, `peak_time ← tmax`, `peak_valid ← 1`.
  - otherwise: drop the new event and increment `lost_count`.
- Handshake:
  - `peak_valid` stays high, with `peak_amp`/`peak_time` stable, until the cycle in which `peak_ready` is high.
  - Simultaneous accept and emit loads the new event with no bubble.
- Counters saturate at 2^CNT_W − 1.
- Reset mid-pulse: the state returns to IDLE with no emission. Any pending event is discarded.

## Timing
- Reset values: `peak_amp` = 0, `peak_time` = 0, `peak_valid` = 0, `lost_count` = 0, `pileup_count` = 0, `ts` = 0, state IDLE.
- The FSM updates on the edge that captures `input_data`. `peak_valid` is high in the cycle following the edge that captured the first sample ≤ `thr_l`.
- `tmax` is the `ts` value present on the edge that captured the maximum sample.
- Equal maxima keep the earlier timestamp, because the update condition is strict `>`.
- The first sample after reset is stamped `ts` = 0.

## Configuration
- `PEAK_PILEUP_REJECT_EN` defined:
  - a rebound in FALL sets a `pileup` flag for the current pulse.
  - at emit, a flagged pulse is discarded: no output load, `pileup_count` increments, and the state still enters HOLDOFF.
  - the flag clears on IDLE→RISE.
- Undefined: rebounds merge into one event reporting the overall maximum, and `pileup_count` reads 0.

## Structure
- Shared package `filter_pkg`: `SIZE_FILTER_DATA`, the state enum `peak_state_t`, and default `HYST`/`HOLDOFF_CYCLES` constants.
- One sub-module, `sat_counter`, with width parameter, synchronous reset, and increment-enable. Instantiated for `lost_count` and `pileup_count`.
- The FSM, `ts` counter and output register stay in `peak_detector`.

## Test plan
- Reset: hold `reset` for 3 cycles with random input → all outputs 0; first post-reset sample stamped `ts` = 0.
- Single pulse, `threshold` = 100, `peak_ready` = 1: samples 0,50,150,300,200,90,0 → one event, `peak_amp` = 300, `peak_time` = ts of the 300 sample, `peak_valid` high for 1 cycle after the 90 edge.
- Boundary: pulse 0,100,100,0 with `threshold` = 100 → no event. Pulse of −50 with `threshold` = −100 → arms, reports −50.
- Back-pressure: `peak_ready` = 0, two pulses with peaks 300 and 500 → first event held stable with `peak_amp` = 300, second dropped, `lost_count` = 1. Raising `peak_ready` clears `peak_valid` next cycle.
- Pile-up, `threshold` = 100, `HYST` = 20: samples 150,300,250,260,280,400,50 → with macro: no event, `pileup_count` = 1. Without: single event with `peak_amp` = 400.
- Holdoff/reset: pulse ending then re-crossing `threshold` within 4 cycles → no second event. Assert `reset` while in RISE → no event, state IDLE, counters 0.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared definitions for the shaping-filter back end: sample width, peak detector
// FSM states and default detector tuning constants.
package filter_pkg;

    localparam int unsigned SIZE_FILTER_DATA       = 16;
    localparam int unsigned HYST_DEFAULT           = 20;
    localparam int unsigned HOLDOFF_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRise,
        StFall,
        StHoldoff
    } peak_state_t;

endpackage

// File: rtl/peak_detector_sat_counter.sv
// Saturating event counter with synchronous active-high reset and increment enable.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/peak_detector.sv
// Pulse-height analyser: per-pulse maximum and its timestamp behind a valid/ready register.
// Define PEAK_PILEUP_REJECT_EN to discard pulses that rebounded during their fall.
module peak_detector
    import filter_pkg::*;
#(
    parameter int unsigned TS_W           = 32,
    parameter int unsigned HYST           = HYST_DEFAULT,
    parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEFAULT,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    output logic signed [SIZE_FILTER_DATA-1:0] peak_amp,
    output logic        [TS_W-1:0]             peak_time,
    output logic                               peak_valid,
    input  logic                               peak_ready,
    output logic        [CNT_W-1:0]            lost_count,
    output logic        [CNT_W-1:0]            pileup_count
);

    localparam int unsigned W   = SIZE_FILTER_DATA;
    localparam int unsigned HCW = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic signed [W:0]   HYST_E    = (W + 1)'(HYST);
    localparam logic        [HCW-1:0] HOLD_LAST = HCW'(HOLDOFF_CYCLES);

    peak_state_t state_q, state_d;

    logic signed [W-1:0] max_q, max_d;
    logic signed [W-1:0] valley_q, valley_d;
    logic signed [W-1:0] thr_q, thr_d;
    logic signed [W-1:0] amp_q, amp_d;
    logic [TS_W-1:0]     ts_q;
    logic [TS_W-1:0]     tmax_q, tmax_d;
    logic [TS_W-1:0]     time_q, time_d;
    logic [HCW-1:0]      hold_q, hold_d;
    logic                valid_q, valid_d;
    logic                pileup_q, pileup_d;

    logic emit;
    logic discard;
    logic load;
    logic lost_inc;

    // Hysteresis arithmetic is one bit wider so max - HYST / valley + HYST cannot wrap.
    logic signed [W:0] x_e, max_e, valley_e;
    assign x_e      = {input_data[W-1], input_data};
    assign max_e    = {max_q[W-1], max_q};
    assign valley_e = {valley_q[W-1], valley_q};

    always_comb begin
        state_d  = state_q;
        max_d    = max_q;
        tmax_d   = tmax_q;
        valley_d = valley_q;
        thr_d    = thr_q;
        hold_d   = hold_q;
        pileup_d = pileup_q;
        emit     = 1'b0;

        case (state_q)
            StIdle: begin
                if (input_data > threshold) begin
                    state_d  = StRise;
                    max_d    = input_data;
                    tmax_d   = ts_q;
                    thr_d    = threshold;
                    pileup_d = 1'b0;
                end
            end
            StRise: begin
                if (input_data > max_q) begin
                    max_d  = input_data;
                    tmax_d = ts_q;
                end else if (input_data <= thr_q) begin
                    emit = 1'b1;
                end else if (x_e < (max_e - HYST_E)) begin
                    state_d  = StFall;
                    valley_d = input_data;
                end
            end
            StFall: begin
                if (input_data <= thr_q) begin
                    emit = 1'b1;
                end else if (input_data < valley_q) begin
                    valley_d = input_data;
                end else if (x_e > (valley_e + HYST_E)) begin
                    state_d  = StRise;
                    pileup_d = 1'b1;
                    if (input_data > max_q) begin
                        max_d  = input_data;
                        tmax_d = ts_q;
                    end
                end
            end
            StHoldoff: begin
                if (hold_q < HOLD_LAST) begin
                    hold_d = hold_q + HCW'(1);
                end else if (input_data <= thr_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (emit) begin
            state_d = StHoldoff;
            hold_d  = '0;
        end
    end

`ifdef PEAK_PILEUP_REJECT_EN
    assign discard = emit && pileup_q;
`else
    assign discard = 1'b0;
`endif

    assign load     = emit && !discard && (!valid_q || peak_ready);
    assign lost_inc = emit && !discard && valid_q && !peak_ready;

    // A load in the accepting cycle replaces the event with no bubble.
    always_comb begin
        amp_d   = amp_q;
        time_d  = time_q;
        valid_d = valid_q;
        if (load) begin
            amp_d   = max_q;
            time_d  = tmax_q;
            valid_d = 1'b1;
        end else if (peak_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            max_q    <= '0;
            tmax_q   <= '0;
            valley_q <= '0;
            thr_q    <= '0;
            hold_q   <= '0;
            pileup_q <= 1'b0;
            ts_q     <= '0;
            amp_q    <= '0;
            time_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            max_q    <= max_d;
            tmax_q   <= tmax_d;
            valley_q <= valley_d;
            thr_q    <= thr_d;
            hold_q   <= hold_d;
            pileup_q <= pileup_d;
            ts_q     <= ts_q + TS_W'(1);
            amp_q    <= amp_d;
            time_q   <= time_d;
            valid_q  <= valid_d;
        end
    end

    assign peak_amp   = amp_q;
    assign peak_time  = time_q;
    assign peak_valid = valid_q;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_lost_count (
        .clk   (clk),
        .reset (reset),
        .inc   (lost_inc),
        .count (lost_count)
    );

`ifdef PEAK_PILEUP_REJECT_EN
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_pileup_count (
        .clk   (clk),
        .reset (reset),
        .inc   (discard),
        .count (pileup_count)
    );
`else
    assign pileup_count = '0;
`endif

endmodule
